line_delay_ctrl: RTL and testbench

One-line pixel delay controller for the image filter pipeline. It drives the write side of the 2048x16 synchronous line FIFO with incoming pixels and drives the read side one line later. Each output beat pairs the current pixel with the vertically aligned pixel from the previous line. Downstream vertical filters consume this (current, above) pair.

---
 rtl/line_delay_ctrl.sv | 141 ++++++++++++++
 tb/tb_line_delay_ctrl.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/line_delay_ctrl.sv
`timescale 1ns/1ps
// One-line pixel delay: writes each line into an external line FIFO and reads it back one line later.
// Output pair (cur, above) appears 2 cycles after s_de; one pixel per clock, no backpressure.
module line_delay_ctrl #(
   parameter int DATA_WIDTH = 16,
   parameter int LINE_WIDTH = 1920,
   parameter int CNT_WIDTH  = 11
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  s_sof,
   input  logic                  s_de,
   input  logic [DATA_WIDTH-1:0] s_data,
   output logic                  fifo_rst,
   output logic                  fifo_wr_en,
   output logic [DATA_WIDTH-1:0] fifo_wr_data,
   output logic                  fifo_rd_en,
   input  logic [DATA_WIDTH-1:0] fifo_rd_data,
   input  logic                  fifo_full,
   input  logic                  fifo_empty,
   output logic                  m_de,
   output logic [DATA_WIDTH-1:0] m_cur,
   output logic [DATA_WIDTH-1:0] m_prev,
   output logic                  m_prev_vld,
   output logic                  m_eol,
   output logic                  err_ovf,
   output logic                  err_udf
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      FLUSH  = 2'd1,
      FILL   = 2'd2,
      STREAM = 2'd3
   } state_t;

   localparam logic [CNT_WIDTH-1:0] COL_LAST = CNT_WIDTH'(LINE_WIDTH - 1);

   state_t                 state_q, state_d;
   logic [CNT_WIDTH-1:0]   col_q, col_d;
   logic                   active;
   logic                   accept;
   logic                   at_last;

   logic                   s1_de;
   logic                   s1_rd;
   logic                   s1_eol;
   logic [DATA_WIDTH-1:0]  s1_data;

   // s_sof wins over everything, so a pixel coincident with it is never taken.
   always_comb begin
      active  = (state_q == FILL) || (state_q == STREAM);
      accept  = s_de & active & ~s_sof;
      at_last = (col_q == COL_LAST);
   end

   always_comb begin
      state_d = state_q;
      col_d   = col_q;
      if (s_sof) begin
         state_d = FLUSH;
         col_d   = '0;
      end else begin
         case (state_q)
            IDLE: begin
               state_d = IDLE;
            end
            FLUSH: begin
               state_d = FILL;
               col_d   = '0;
            end
            FILL: begin
               if (s_de) begin
                  if (at_last) begin
                     col_d   = '0;
                     state_d = STREAM;
                  end else begin
                     col_d = col_q + CNT_WIDTH'(1);
                  end
               end
            end
            STREAM: begin
               if (s_de) begin
                  col_d = at_last ? '0 : col_q + CNT_WIDTH'(1);
               end
            end
            default: begin
               state_d = IDLE;
               col_d   = '0;
            end
         endcase
      end
   end

   assign fifo_wr_en   = accept & ~fifo_full;
   assign fifo_wr_data = s_data;
   assign fifo_rd_en   = accept & (state_q == STREAM) & ~fifo_empty;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= IDLE;
         col_q    <= '0;
         fifo_rst <= 1'b0;
         err_ovf  <= 1'b0;
         err_udf  <= 1'b0;
      end else begin
         state_q  <= state_d;
         col_q    <= col_d;
         // Every s_sof lands in FLUSH next cycle, so the flush pulse is just s_sof delayed.
         fifo_rst <= s_sof;
         err_ovf  <= err_ovf | (accept & fifo_full);
         err_udf  <= err_udf | (accept & (state_q == STREAM) & fifo_empty);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1_de      <= 1'b0;
         s1_rd      <= 1'b0;
         s1_eol     <= 1'b0;
         s1_data    <= '0;
         m_de       <= 1'b0;
         m_cur      <= '0;
         m_prev     <= '0;
         m_prev_vld <= 1'b0;
         m_eol      <= 1'b0;
      end else begin
         s1_de      <= accept;
         s1_rd      <= fifo_rd_en;
         s1_eol     <= accept & at_last;
         s1_data    <= s_data;
         // Read data arrives one cycle after fifo_rd_en, aligned with stage 1.
         m_de       <= s1_de;
         m_cur      <= s1_data;
         m_prev     <= s1_rd ? fifo_rd_data : '0;
         m_prev_vld <= s1_rd;
         m_eol      <= s1_eol;
      end
   end

endmodule

// File: tb/tb_line_delay_ctrl.sv
`timescale 1ns/1ps
// Scoreboarded random + directed bench for line_delay_ctrl with a behavioural line FIFO.
module tb_line_delay_ctrl;

   localparam int DW = 16;
   localparam int LW = 4;
   localparam int CW = 11;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          s_sof = 1'b0;
   logic          s_de = 1'b0;
   logic [DW-1:0] s_data = '0;
   logic          fifo_rst, fifo_wr_en, fifo_rd_en;
   logic [DW-1:0] fifo_wr_data;
   logic [DW-1:0] fifo_rd_data;
   logic          fifo_full, fifo_empty;
   logic          m_de, m_prev_vld, m_eol, err_ovf, err_udf;
   logic [DW-1:0] m_cur, m_prev;

   always #5 clk = ~clk;

   line_delay_ctrl #(.DATA_WIDTH(DW), .LINE_WIDTH(LW), .CNT_WIDTH(CW)) dut (
      .clk(clk), .rst(rst), .s_sof(s_sof), .s_de(s_de), .s_data(s_data),
      .fifo_rst(fifo_rst), .fifo_wr_en(fifo_wr_en), .fifo_wr_data(fifo_wr_data),
      .fifo_rd_en(fifo_rd_en), .fifo_rd_data(fifo_rd_data),
      .fifo_full(fifo_full), .fifo_empty(fifo_empty),
      .m_de(m_de), .m_cur(m_cur), .m_prev(m_prev), .m_prev_vld(m_prev_vld),
      .m_eol(m_eol), .err_ovf(err_ovf), .err_udf(err_udf)
   );

   // Behavioural 2048-deep line FIFO, read data one cycle after rd_en.
   logic [DW-1:0] fq[$];
   int            fsize = 0;
   bit            force_full = 0, force_empty = 0;

   assign fifo_full  = force_full  | (fsize >= 2048);
   assign fifo_empty = force_empty | (fsize == 0);

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         fq.delete();
         fsize        <= 0;
         fifo_rd_data <= '0;
      end else begin
         if (fifo_rst) begin
            fq.delete();
         end else begin
            if (fifo_rd_en && fq.size() > 0) fifo_rd_data <= fq.pop_front();
            if (fifo_wr_en) fq.push_back(fifo_wr_data);
         end
         fsize <= fq.size();
      end
   end

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      logic [DW-1:0] cur;
      logic [DW-1:0] prev;
      logic          vld;
      logic          eol;
      int            t;
   } beat_t;

   beat_t expq[$];
   int    nvec = 0;
   int    nfail = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      nvec++;
      if (act !== exp) begin
         nfail++;
         $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Monitor: every output beat must match the oldest expected beat, on its exact cycle.
   always @(negedge clk) begin : mon
      beat_t b;
      if (!rst) begin
         if (m_de) begin
            if (expq.size() == 0) begin
               nvec++;
               nfail++;
               $display("FAIL unexpected_beat: m_de=1 m_cur=%h, expected no beat (cycle %0d)", m_cur, cyc);
            end else begin
               b = expq.pop_front();
               chk("m_cur",      32'(m_cur),      32'(b.cur));
               chk("m_prev",     32'(m_prev),     32'(b.prev));
               chk("m_prev_vld", 32'(m_prev_vld), 32'(b.vld));
               chk("m_eol",      32'(m_eol),      32'(b.eol));
               chk("latency_cycle", 32'(cyc),     32'(b.t));
            end
         end else if (expq.size() > 0 && expq[0].t < cyc) begin
            b = expq.pop_front();
            nvec++;
            nfail++;
            $display("FAIL missing_beat: m_de=0, expected beat cur=%h at cycle %0d", b.cur, b.t);
         end
      end
   end

   // Reference model: a frame is a stack of lines; the "above" pixel is simply
   // the pixel at the same column of the previous line of the same frame.
   logic [DW-1:0] img[0:7][0:LW-1];
   int            m_line = 0, m_col = 0;
   bit            m_active = 0;
   bit            exp_ovf = 0, exp_udf = 0;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      repeat (n) tick();
   endtask

   task automatic sof();
      s_sof = 1'b1;
      tick();
      s_sof = 1'b0;
      chk("fifo_rst_flush", 32'(fifo_rst), 32'd1);
      m_active = 1;
      m_line   = 0;
      m_col    = 0;
      tick();
      chk("fifo_rst_after", 32'(fifo_rst), 32'd0);
      tick();
   endtask

   task automatic pixel(input logic [DW-1:0] d, input bit ff, input bit fe);
      beat_t b;
      bit    exp_wr, exp_rd;
      s_de        = 1'b1;
      s_data      = d;
      force_full  = ff;
      force_empty = fe;
      #1;
      if (m_active) begin
         b.cur = d;
         b.eol = (m_col == LW - 1);
         b.t   = cyc + 2;
         if (m_line == 0 || fe) begin
            b.prev = '0;
            b.vld  = 1'b0;
         end else begin
            b.prev = img[(m_line - 1) % 8][m_col];
            b.vld  = 1'b1;
         end
         exp_wr = !ff;
         exp_rd = (m_line > 0) && !fe;
         if (ff) exp_ovf = 1;
         if (fe && m_line > 0) exp_udf = 1;
         img[m_line % 8][m_col] = d;
         expq.push_back(b);
         if (m_col == LW - 1) begin
            m_col = 0;
            m_line++;
         end else begin
            m_col++;
         end
      end else begin
         exp_wr = 0;
         exp_rd = 0;
      end
      chk("fifo_wr_en", 32'(fifo_wr_en), 32'(exp_wr));
      chk("fifo_rd_en", 32'(fifo_rd_en), 32'(exp_rd));
      if (exp_wr) chk("fifo_wr_data", 32'(fifo_wr_data), 32'(d));
      tick();
      s_de        = 1'b0;
      force_full  = 0;
      force_empty = 0;
      chk("err_ovf", 32'(err_ovf), 32'(exp_ovf));
      chk("err_udf", 32'(err_udf), 32'(exp_udf));
   endtask

   task automatic check_all_zero(input string tag);
      chk({tag, "_m_de"},       32'(m_de),       32'd0);
      chk({tag, "_m_cur"},      32'(m_cur),      32'd0);
      chk({tag, "_m_prev"},     32'(m_prev),     32'd0);
      chk({tag, "_m_prev_vld"}, 32'(m_prev_vld), 32'd0);
      chk({tag, "_m_eol"},      32'(m_eol),      32'd0);
      chk({tag, "_fifo_wr_en"}, 32'(fifo_wr_en), 32'd0);
      chk({tag, "_fifo_rd_en"}, 32'(fifo_rd_en), 32'd0);
      chk({tag, "_fifo_rst"},   32'(fifo_rst),   32'd0);
      chk({tag, "_err_ovf"},    32'(err_ovf),    32'd0);
      chk({tag, "_err_udf"},    32'(err_udf),    32'd0);
   endtask

   initial begin : watchdog
      #300000;
      $display("FAIL watchdog: simulation still running at time limit, expected completion");
      $fatal(1);
   end

   initial begin : stim
      int  nl, ab_line, ab_col, errk;
      bit  stop, last;

      tick();
      check_all_zero("reset");
      tick();
      rst = 1'b0;
      idle(2);

      // Pixels before any s_sof are ignored.
      for (int i = 0; i < 3; i++) pixel(16'(16'h00a0 + i), 0, 0);
      idle(2);

      // Basic two-line delay, back to back.
      sof();
      idle(1);
      for (int i = 1; i <= 4; i++) pixel(16'(i), 0, 0);
      for (int i = 1; i <= 4; i++) pixel(16'(16'h0010 + i), 0, 0);
      idle(3);

      // Gapped input.
      sof();
      idle(1);
      for (int i = 1; i <= 4; i++) begin pixel(16'(i), 0, 0); idle(1); end
      for (int i = 1; i <= 4; i++) begin pixel(16'(16'h0010 + i), 0, 0); idle(1); end
      idle(3);

      // Mid-line abort followed by a fresh frame.
      sof();
      for (int i = 1; i <= 4; i++) pixel(16'(16'h0100 + i), 0, 0);
      for (int i = 1; i <= 2; i++) pixel(16'(16'h0110 + i), 0, 0);
      sof();
      for (int i = 1; i <= 4; i++) pixel(16'(16'h0200 + i), 0, 0);
      for (int i = 1; i <= 4; i++) pixel(16'(16'h0210 + i), 0, 0);
      idle(3);

      // Overflow on the last FILL pixel; underflow on the last STREAM pixel.
      sof();
      for (int i = 1; i <= 4; i++) pixel(16'(16'h0300 + i), i == 4, 0);
      sof();
      for (int i = 1; i <= 4; i++) pixel(16'(16'h0400 + i), 0, 0);
      for (int i = 1; i <= 4; i++) pixel(16'(16'h0410 + i), 0, i == 4);
      idle(3);

      // Randomised frames with gaps, aborts and occasional errors at frame end.
      for (int f = 0; f < 25; f++) begin
         nl      = $urandom_range(1, 4);
         ab_line = ($urandom_range(0, 3) == 0) ? $urandom_range(0, nl - 1) : -1;
         ab_col  = $urandom_range(0, LW - 1);
         errk    = $urandom_range(0, 5);
         stop    = 0;
         sof();
         for (int l = 0; l < nl; l++) begin
            for (int c = 0; c < LW; c++) begin
               if (l == ab_line && c == ab_col) stop = 1;
               if (!stop) begin
                  last = (l == nl - 1) && (c == LW - 1);
                  pixel(16'($urandom), last && errk == 0, last && errk == 1 && nl > 1);
                  if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 3));
               end
            end
         end
         idle($urandom_range(0, 3));
      end

      // Asynchronous reset in the middle of a streaming line.
      sof();
      for (int i = 1; i <= 4; i++) pixel(16'(16'h0500 + i), 0, 0);
      for (int i = 1; i <= 2; i++) pixel(16'(16'h0510 + i), 0, 0);
      #2;
      rst = 1'b1;
      #1;
      check_all_zero("async_rst");
      expq.delete();
      m_active = 0;
      exp_ovf  = 0;
      exp_udf  = 0;
      tick();
      tick();
      rst = 1'b0;
      for (int i = 0; i < 4; i++) pixel(16'(16'h0600 + i), 0, 0);
      idle(3);
      sof();
      for (int i = 1; i <= 4; i++) pixel(16'(16'h0700 + i), 0, 0);
      for (int i = 1; i <= 4; i++) pixel(16'(16'h0710 + i), 0, 0);

      idle(4);
      nvec++;
      if (expq.size() != 0) begin
         nfail++;
         $display("FAIL drain: %0d beats still pending, expected 0", expq.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
      $finish;
   end

endmodule
